// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and constants for the dual-FIFO burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam int NUM_SRC = 2;

    // One-hot grant vector seen by the outside world for a given state.
    function automatic logic [NUM_SRC-1:0] grant_of(input arb_state_t s);
        case (s)
            ARB_GNT0: grant_of = 2'b01;
            ARB_GNT1: grant_of = 2'b10;
            default:  grant_of = 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arb_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_out_reg
// Purpose  : Single-entry valid/ready output register with full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_arb_out_reg
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_src,
    input  logic              i_out_rdy,
    output logic              o_load_en,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_src,
    output logic              o_out_vld
);

    logic [DATA_W-1:0] r_data;
    logic              r_src;
    logic              r_vld;

    // The slot can take a new beat when empty or being drained this cycle.
    assign o_load_en = !r_vld || i_out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_src  <= 1'b0;
            r_vld  <= 1'b0;
        end else if (o_load_en) begin
            if (i_load) begin
                r_data <= i_load_data;
                r_src  <= i_load_src;
                r_vld  <= 1'b1;
            end else begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign o_out_data = r_data;
    assign o_out_src  = r_src;
    assign o_out_vld  = r_vld;

endmodule
`default_nettype wire

// File: rtl/fifo_pair_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pair_arbiter
// Purpose  : Round-robin burst arbiter merging two 16-bit FIFO streams.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pair_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_vld,
    output logic               in0_rdy,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_vld,
    output logic               in1_rdy,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_vld,
    output logic               out_src,
    input  logic               out_rdy,
    output logic [NUM_SRC-1:0] grant
);

    localparam int                 c_cnt_w     = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);

    arb_state_t         r_state;
    logic               r_prio;
    logic [c_cnt_w-1:0] r_beat_cnt;

    logic               w_load_en;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_acc;
    logic               w_gsel;
    logic               w_vld_g;
    logic               w_vld_o;
    logic               w_release;
    arb_state_t         w_own_gnt;
    arb_state_t         w_other_gnt;

    // rst gates rdy so no FIFO is popped into a beat that reset discards.
    assign in0_rdy = !rst && w_load_en && (r_state == ARB_GNT0);
    assign in1_rdy = !rst && w_load_en && (r_state == ARB_GNT1);

    assign w_acc0 = in0_vld && in0_rdy;
    assign w_acc1 = in1_vld && in1_rdy;
    assign w_acc  = w_acc0 || w_acc1;

    assign w_gsel      = (r_state == ARB_GNT1);
    assign w_vld_g     = w_gsel ? in1_vld : in0_vld;
    assign w_vld_o     = w_gsel ? in0_vld : in1_vld;
    assign w_own_gnt   = w_gsel ? ARB_GNT1 : ARB_GNT0;
    assign w_other_gnt = w_gsel ? ARB_GNT0 : ARB_GNT1;

    // A grant ends on its last beat or as soon as its source goes empty,
    // even while stalled, so a dry FIFO never blocks the other one.
    assign w_release = ((r_state == ARB_GNT0) || (r_state == ARB_GNT1)) &&
                       ((w_acc && (r_beat_cnt == c_last_beat)) || !w_vld_g);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (in0_vld && in1_vld)
                        r_state <= r_prio ? ARB_GNT1 : ARB_GNT0;
                    else if (in0_vld)
                        r_state <= ARB_GNT0;
                    else if (in1_vld)
                        r_state <= ARB_GNT1;
                end
                ARB_GNT0, ARB_GNT1: begin
                    if (w_release) begin
                        r_prio     <= ~w_gsel;
                        r_beat_cnt <= '0;
                        if (w_vld_o)
                            r_state <= w_other_gnt;
                        else if (w_vld_g)
                            r_state <= w_own_gnt;
                        else
                            r_state <= ARB_IDLE;
                    end else if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign grant = grant_of(r_state);

    fifo_arb_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_acc),
        .i_load_data (w_acc1 ? in1_data : in0_data),
        .i_load_src  (w_acc1),
        .i_out_rdy   (out_rdy),
        .o_load_en   (w_load_en),
        .o_out_data  (out_data),
        .o_out_src   (out_src),
        .o_out_vld   (out_vld)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_pair_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pair_arbiter
// Purpose  : Scoreboard bench for the dual-FIFO burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pair_arbiter;

    typedef struct {
        logic [15:0] data;
        logic        src;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in0_data, in1_data, out_data;
    logic        in0_vld, in0_rdy, in1_vld, in1_rdy;
    logic        out_vld, out_src, out_rdy;
    logic [1:0]  grant;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    beat_t       obs[$];
    beat_t       exp_q[$];
    bit          hold0, hold1, saw_rdy;
    int          cycle;
    int          n_cmp, n_bad;

    always #5 clk = ~clk;

    fifo_pair_arbiter #(.DATA_W(16), .BURST_LEN(2)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_vld(in0_vld), .in0_rdy(in0_rdy),
        .in1_data(in1_data), .in1_vld(in1_vld), .in1_rdy(in1_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_src(out_src),
        .out_rdy(out_rdy), .grant(grant)
    );

    // One clock: present source heads, sample handshakes, pop on accept.
    task automatic tick();
        bit    a0, a1;
        beat_t b;
        in0_vld  = (q0.size() > 0) && !hold0;
        in0_data = (q0.size() > 0) ? q0[0] : 16'h0;
        in1_vld  = (q1.size() > 0) && !hold1;
        in1_data = (q1.size() > 0) ? q1[0] : 16'h0;
        #1;
        a0      = in0_vld && in0_rdy;
        a1      = in1_vld && in1_rdy;
        saw_rdy = in0_rdy || in1_rdy;
        if (out_vld && out_rdy) begin
            b.data = out_data; b.src = out_src; b.cyc = cycle;
            obs.push_back(b);
        end
        @(posedge clk);
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        cycle++;
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int i = 0;
        while (obs.size() < n && i < budget) begin
            tick();
            i++;
        end
        ok = (obs.size() >= n);
    endtask

    task automatic push_exp(input logic [15:0] d, input logic s);
        beat_t e;
        e.data = d; e.src = s; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; out_rdy = 1'b1; hold0 = 0; hold1 = 0;
        q0.delete(); q1.delete();
        tick(); tick();
        rst = 1'b0;
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
            n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
            n_cmp++; if (saw_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", saw_rdy); end
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (grant !== 2'b00 || out_vld !== 1'b0) begin n_bad++; $display("FAIL idle_state: got grant=%b vld=%b want 00/0", grant, out_vld); end
        n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL idle_output: got %0d beats want 0", obs.size()); end
        obs.delete();
    endtask

    task automatic test_single();
        bit    ok, gap;
        beat_t e, o;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(16'hA000 + 16'(i));
            push_exp(16'hA000 + 16'(i), 1'b0);
        end
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", grant); end
        run_until(4, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d beats want 4", obs.size()); end
        gap = 0;
        for (int i = 1; i < obs.size(); i++) if (obs[i].cyc != obs[0].cyc + i) gap = 1;
        n_cmp++; if (gap) begin n_bad++; $display("FAIL single_bubble: got gap want back-to-back"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_bad++; $display("FAIL single_missing: got none want %h", e.data); end
            else begin
                o = obs.pop_front();
                if (o.data !== e.data || o.src !== e.src) begin n_bad++; $display("FAIL single_beat: got %h/%b want %h/%b", o.data, o.src, e.data, e.src); end
            end
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (obs.size() != 0 || grant !== 2'b00) begin n_bad++; $display("FAIL single_drain: got %0d extra grant=%b want 0/00", obs.size(), grant); end
    endtask

    task automatic test_contention();
        bit    ok, gap;
        beat_t e, o;
        do_reset();
        for (int i = 1; i <= 4; i++) q0.push_back(16'h0000 + 16'(i));
        for (int i = 1; i <= 2; i++) q1.push_back(16'h1000 + 16'(i));
        push_exp(16'h0001, 1'b0); push_exp(16'h0002, 1'b0);
        push_exp(16'h1001, 1'b1); push_exp(16'h1002, 1'b1);
        push_exp(16'h0003, 1'b0); push_exp(16'h0004, 1'b0);
        run_until(6, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL contend_timeout: got %0d beats want 6", obs.size()); end
        gap = 0;
        for (int i = 1; i < obs.size(); i++) if (obs[i].cyc != obs[0].cyc + i) gap = 1;
        n_cmp++; if (gap) begin n_bad++; $display("FAIL contend_bubble: got gap want back-to-back"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_bad++; $display("FAIL contend_missing: got none want %h", e.data); end
            else begin
                o = obs.pop_front();
                if (o.data !== e.data || o.src !== e.src) begin n_bad++; $display("FAIL contend_beat: got %h/%b want %h/%b", o.data, o.src, e.data, e.src); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        logic [15:0] held;
        beat_t       e, o;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(16'hB000 + 16'(i));
            push_exp(16'hB000 + 16'(i), 1'b0);
        end
        run_until(1, 10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_start: got %0d beats want 1", obs.size()); end
        out_rdy = 1'b0;
        held = out_data;
        n_cmp++; if (out_vld !== 1'b1 || held !== 16'hB002) begin n_bad++; $display("FAIL bp_hold_entry: got %b/%h want 1/b002", out_vld, held); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (saw_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy: got %b want 0", saw_rdy); end
            n_cmp++; if (out_vld !== 1'b1 || out_data !== held) begin n_bad++; $display("FAIL bp_stable: got %b/%h want 1/%h", out_vld, out_data, held); end
        end
        out_rdy = 1'b1;
        run_until(4, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: got %0d beats want 4", obs.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_bad++; $display("FAIL bp_missing: got none want %h", e.data); end
            else begin
                o = obs.pop_front();
                if (o.data !== e.data || o.src !== e.src) begin n_bad++; $display("FAIL bp_beat: got %h/%b want %h/%b", o.data, o.src, e.data, e.src); end
            end
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL bp_dup: got %0d extra want 0", obs.size()); end
    endtask

    task automatic test_early_release();
        bit    ok;
        beat_t e, o;
        do_reset();
        q1.push_back(16'h1001); q1.push_back(16'h1002);
        tick();
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL early_grant1: got %b want 10", grant); end
        q0.push_back(16'h0001); q0.push_back(16'h0002);
        push_exp(16'h1001, 1'b1); push_exp(16'h0001, 1'b0); push_exp(16'h0002, 1'b0);
        tick();
        hold1 = 1;
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL early_switch: got %b want 01", grant); end
        run_until(3, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL early_timeout: got %0d beats want 3", obs.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_bad++; $display("FAIL early_missing: got none want %h", e.data); end
            else begin
                o = obs.pop_front();
                if (o.data !== e.data || o.src !== e.src) begin n_bad++; $display("FAIL early_beat: got %h/%b want %h/%b", o.data, o.src, e.data, e.src); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit    ok;
        beat_t o;
        do_reset();
        for (int i = 1; i <= 3; i++) q1.push_back(16'h1000 + 16'(i));
        tick(); tick();
        n_cmp++; if (out_vld !== 1'b1 || grant !== 2'b10) begin n_bad++; $display("FAIL rmid_pre: got %b/%b want 1/10", out_vld, grant); end
        q0.push_back(16'h0001); q0.push_back(16'h0002);
        rst = 1'b1;
        tick();
        n_cmp++; if (saw_rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_rdy: got %b want 0", saw_rdy); end
        n_cmp++; if (out_vld !== 1'b0 || grant !== 2'b00) begin n_bad++; $display("FAIL rmid_state: got %b/%b want 0/00", out_vld, grant); end
        n_cmp++; if (dut.r_prio !== 1'b0 || dut.r_beat_cnt !== '0) begin n_bad++; $display("FAIL rmid_prio: got %b/%0d want 0/0", dut.r_prio, dut.r_beat_cnt); end
        rst = 1'b0;
        obs.delete();
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rmid_regrant: got %b want 01", grant); end
        run_until(1, 10, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rmid_first: got none want 0001"); end
        else begin
            o = obs.pop_front();
            if (o.data !== 16'h0001 || o.src !== 1'b0) begin n_bad++; $display("FAIL rmid_first: got %h/%b want 0001/0", o.data, o.src); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cycle = 0;
        rst = 1'b1; out_rdy = 1'b1; hold0 = 0; hold1 = 0;
        in0_vld = 1'b0; in1_vld = 1'b0; in0_data = '0; in1_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
